// File: rtl/ccm_pkg.sv
// Shared field widths for the CCM counter-block format.
package ccm_pkg;

    localparam int unsigned FLAG_W   = 8;
    localparam int unsigned SECTOR_W = 4;
    localparam int unsigned FRAME_W  = 48;
    localparam int unsigned SLOT_W   = 4;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned BLOCK_W  = 128;

    // Low part of the block shared between stream index and block counter
    localparam int unsigned CTR_FIELD_W =
        BLOCK_W - FLAG_W - SECTOR_W - FRAME_W - SLOT_W - ADDR_W;

    // Index width for a stream count, never narrower than one bit
    function automatic int unsigned sidx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccm_ctr_slice.sv
// One stream's block counter and sticky counter-exhausted flag.
module ccm_ctr_slice #(
    parameter int unsigned WIDTH_COUNT = 20
) (
    input  logic                   i_clk,
    input  logic                   i_kill,
    input  logic                   i_restart,
    input  logic                   i_advance,
    output logic [WIDTH_COUNT-1:0] o_count_use,
    output logic                   o_overflow
);

    logic [WIDTH_COUNT-1:0] r_count;
    logic                   r_overflow;
    logic [WIDTH_COUNT-1:0] w_count_nxt;
    logic                   w_overflow_nxt;
    logic                   w_at_max;

    // A restart in the same cycle as a request wins, so the request sees count 1
    assign o_count_use = i_restart ? WIDTH_COUNT'(1) : r_count;
    assign w_at_max    = &o_count_use;
    assign o_overflow  = r_overflow;

    // Next counter: restart first, then advance; saturate at all-ones and flag it
    always_comb begin
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        if (i_restart) begin
            w_count_nxt    = WIDTH_COUNT'(1);
            w_overflow_nxt = 1'b0;
        end
        if (i_advance) begin
            if (w_at_max) begin
                w_count_nxt    = o_count_use;
                w_overflow_nxt = 1'b1;
            end else begin
                w_count_nxt = o_count_use + WIDTH_COUNT'(1);
            end
        end
    end

    // Counter state register with synchronous kill
    always_ff @(posedge i_clk) begin
        if (i_kill) begin
            r_count    <= WIDTH_COUNT'(1);
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

endmodule

// File: rtl/ccm_ctr_gen.sv
// CCM counter-block generator: per-stream counters feeding a one-deep output register.
module ccm_ctr_gen
    import ccm_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = 2,
    parameter int unsigned WIDTH_COUNT = 20,
    parameter int unsigned WIDTH_SIDX  = sidx_width(NUM_STREAMS)
) (
    input  logic                   clk,
    input  logic                   kill,
    input  logic [FLAG_W-1:0]      ccm_ctr_flag,
    input  logic [SECTOR_W-1:0]    nonce_sector_id,
    input  logic [FRAME_W-1:0]     nonce_frame_id,
    input  logic [SLOT_W-1:0]      nonce_start_slot_idx,
    input  logic [ADDR_W-1:0]      nonce_addr_idx,
    input  logic                   in_valid,
    input  logic [WIDTH_SIDX-1:0]  in_stream_idx,
    output logic                   in_ready,
    input  logic                   ctr_restart,
    input  logic [WIDTH_SIDX-1:0]  ctr_restart_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLOCK_W-1:0]     ctr_block,
    output logic [WIDTH_SIDX-1:0]  out_stream_idx,
    output logic [NUM_STREAMS-1:0] ctr_overflow
);

    localparam int unsigned STREAM_FIELD_W = CTR_FIELD_W - WIDTH_COUNT;

    if (WIDTH_SIDX + WIDTH_COUNT > CTR_FIELD_W) begin : g_bad_width
        $error("ccm_ctr_gen: WIDTH_SIDX + WIDTH_COUNT exceeds the counter field");
    end
    if (NUM_STREAMS > 2 ** WIDTH_SIDX) begin : g_bad_sidx
        $error("ccm_ctr_gen: WIDTH_SIDX too narrow for NUM_STREAMS");
    end
    if (NUM_STREAMS < 1 || NUM_STREAMS > 16) begin : g_bad_streams
        $error("ccm_ctr_gen: NUM_STREAMS out of range 1..16");
    end

    logic [WIDTH_COUNT-1:0]    w_count_use [NUM_STREAMS];
    logic [NUM_STREAMS-1:0]    w_advance;
    logic [NUM_STREAMS-1:0]    w_restart;
    logic [WIDTH_COUNT-1:0]    w_sel_count;
    logic                      w_sel_ovf;
    logic                      w_idx_ok;
    logic                      w_accept;
    logic [STREAM_FIELD_W-1:0] w_sfield;
    logic [BLOCK_W-1:0]        w_block;

    logic                      r_out_valid;
    logic [BLOCK_W-1:0]        r_ctr_block;
    logic [WIDTH_SIDX-1:0]     r_out_sidx;

    // Per-stream counter slices
    for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_slice
        assign w_advance[s] = w_accept & (in_stream_idx == WIDTH_SIDX'(s));
        assign w_restart[s] = ctr_restart & (ctr_restart_idx == WIDTH_SIDX'(s));

        ccm_ctr_slice #(
            .WIDTH_COUNT (WIDTH_COUNT)
        ) u_slice (
            .i_clk       (clk),
            .i_kill      (kill),
            .i_restart   (w_restart[s]),
            .i_advance   (w_advance[s]),
            .o_count_use (w_count_use[s]),
            .o_overflow  (ctr_overflow[s])
        );
    end

    assign w_idx_ok = 32'(in_stream_idx) < NUM_STREAMS;

    // Select the requested stream's count and overflow; out-of-range indices select nothing
    always_comb begin
        w_sel_count = '0;
        w_sel_ovf   = 1'b0;
        for (int s = 0; s < int'(NUM_STREAMS); s++) begin
            if (in_stream_idx == WIDTH_SIDX'(s)) begin
                w_sel_count = w_count_use[s];
                w_sel_ovf   = ctr_overflow[s];
            end
        end
    end

    assign in_ready = ~kill & w_idx_ok & (~r_out_valid | out_ready) & ~w_sel_ovf;
    assign w_accept = in_valid & in_ready;

    // Zero-extend the stream index into the field between nonce and counter
    always_comb begin
        w_sfield                   = '0;
        w_sfield[WIDTH_SIDX-1:0]   = in_stream_idx;
    end

    assign w_block = {ccm_ctr_flag, nonce_sector_id, nonce_frame_id, nonce_start_slot_idx,
                      nonce_addr_idx, w_sfield, w_sel_count};

    // Output register: load on acceptance, hold while stalled, drop once taken
    always_ff @(posedge clk) begin
        if (kill) begin
            r_out_valid <= 1'b0;
            r_ctr_block <= '0;
            r_out_sidx  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_ctr_block <= w_block;
            r_out_sidx  <= in_stream_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign ctr_block      = r_ctr_block;
    assign out_stream_idx = r_out_sidx;

endmodule

// File: tb/tb_ccm_ctr_gen.sv
// Directed + random bench for ccm_ctr_gen with a scoreboard of issued blocks.
module tb_ccm_ctr_gen;

    localparam int unsigned NS = 3;
    localparam int unsigned WC = 4;
    localparam int unsigned WS = 2;

    typedef struct {
        logic [WS-1:0] sidx;
        logic [127:0]  blk;
    } exp_t;

    logic          clk = 1'b0;
    logic          kill;
    logic [7:0]    ccm_ctr_flag;
    logic [3:0]    nonce_sector_id;
    logic [47:0]   nonce_frame_id;
    logic [3:0]    nonce_start_slot_idx;
    logic [7:0]    nonce_addr_idx;
    logic          in_valid;
    logic [WS-1:0] in_stream_idx;
    logic          in_ready;
    logic          ctr_restart;
    logic [WS-1:0] ctr_restart_idx;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  ctr_block;
    logic [WS-1:0] out_stream_idx;
    logic [NS-1:0] ctr_overflow;

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          q[$];
    int            m_cnt[NS];
    logic [NS-1:0] m_ovf;

    always #5 clk = ~clk;

    ccm_ctr_gen #(
        .NUM_STREAMS (NS),
        .WIDTH_COUNT (WC)
    ) u_dut (
        .clk                  (clk),
        .kill                 (kill),
        .ccm_ctr_flag         (ccm_ctr_flag),
        .nonce_sector_id      (nonce_sector_id),
        .nonce_frame_id       (nonce_frame_id),
        .nonce_start_slot_idx (nonce_start_slot_idx),
        .nonce_addr_idx       (nonce_addr_idx),
        .in_valid             (in_valid),
        .in_stream_idx        (in_stream_idx),
        .in_ready             (in_ready),
        .ctr_restart          (ctr_restart),
        .ctr_restart_idx      (ctr_restart_idx),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .ctr_block            (ctr_block),
        .out_stream_idx       (out_stream_idx),
        .ctr_overflow         (ctr_overflow)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check in_ready, update model, check outputs
    task automatic step(input logic k, input logic v, input logic [WS-1:0] idx,
                        input logic rs, input logic [WS-1:0] ridx, input logic ordy);
        logic   exp_rdy;
        logic   acc;
        int     ii;
        int     ri;
        int     u;
        exp_t   e;
        @(negedge clk);
        kill = k; in_valid = v; in_stream_idx = idx;
        ctr_restart = rs; ctr_restart_idx = ridx; out_ready = ordy;
        #1;
        ii = int'(idx);
        ri = int'(ridx);
        exp_rdy = 1'b0;
        if (!k && ii < int'(NS))
            exp_rdy = ((q.size() == 0) || ordy) && !m_ovf[ii];
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        acc = v && exp_rdy;
        u = 0;
        if (acc) begin
            u = (rs && ri == ii) ? 1 : m_cnt[ii];
            e.sidx = idx;
            e.blk  = {ccm_ctr_flag, nonce_sector_id, nonce_frame_id, nonce_start_slot_idx,
                      nonce_addr_idx, 52'(idx), 4'(u)};
        end
        @(posedge clk);
        #1;
        if (k) begin
            q.delete();
            for (int s = 0; s < int'(NS); s++) m_cnt[s] = 1;
            m_ovf = '0;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (rs && ri < int'(NS)) begin
                m_cnt[ri] = 1;
                m_ovf[ri] = 1'b0;
            end
            if (acc) begin
                if (u == 15) begin
                    m_cnt[ii] = 15;
                    m_ovf[ii] = 1'b1;
                end else begin
                    m_cnt[ii] = u + 1;
                end
            end
        end
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        if (q.size() > 0) begin
            chk("ctr_block", ctr_block, q[0].blk);
            chk("out_stream_idx", 128'(out_stream_idx), 128'(q[0].sidx));
        end
        chk("ctr_overflow", 128'(ctr_overflow), 128'(m_ovf));
    endtask

    initial begin
        kill = 1'b0; in_valid = 1'b0; in_stream_idx = '0; ctr_restart = 1'b0;
        ctr_restart_idx = '0; out_ready = 1'b0;
        ccm_ctr_flag = 8'h00; nonce_sector_id = 4'h0; nonce_frame_id = 48'h0;
        nonce_start_slot_idx = 4'h0; nonce_addr_idx = 8'h00;
        for (int s = 0; s < int'(NS); s++) m_cnt[s] = 1;
        m_ovf = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        chk("rst_block", ctr_block, 128'h0);
        chk("rst_sidx", 128'(out_stream_idx), 128'h0);

        // Basic sequence: stream0, stream0, stream1
        ccm_ctr_flag = 8'h59; nonce_frame_id = 48'h1; nonce_sector_id = 4'h3;
        nonce_start_slot_idx = 4'h5; nonce_addr_idx = 8'hA7;
        step(0, 1, 0, 0, 0, 1);
        chk("seq_cnt0", 128'(ctr_block[3:0]), 128'h1);
        chk("seq_sf0", 128'(ctr_block[55:4]), 128'h0);
        chk("seq_flag", 128'(ctr_block[127:120]), 128'h59);
        step(0, 1, 0, 0, 0, 1);
        chk("seq_cnt1", 128'(ctr_block[3:0]), 128'h2);
        step(0, 1, 1, 0, 0, 1);
        chk("seq_cnt2", 128'(ctr_block[3:0]), 128'h1);
        chk("seq_sf2", 128'(ctr_block[55:4]), 128'h1);
        step(0, 0, 0, 0, 0, 1);

        // Backpressure: one block held for three cycles, then resume
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("hold_cnt", 128'(ctr_block[3:0]), 128'h2);
        end
        step(0, 1, 1, 0, 0, 1);
        chk("resume_cnt", 128'(ctr_block[3:0]), 128'h3);
        step(0, 0, 0, 0, 0, 1);

        // Exhaust stream0 from a fresh start
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 1);
        chk("ovf_cnt", 128'(ctr_block[3:0]), 128'hF);
        chk("ovf_flag0", 128'(ctr_overflow[0]), 128'h1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        chk("ovf_s1_served", 128'(out_stream_idx), 128'h1);

        // Restart priority over a same-cycle request
        step(0, 1, 0, 1, 0, 1);
        chk("rst_clr_ovf", 128'(ctr_overflow[0]), 128'h0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("pre_restart", 128'(ctr_block[3:0]), 128'h2);
        step(0, 1, 0, 1, 0, 1);
        chk("restart_cnt", 128'(ctr_block[3:0]), 128'h1);
        step(0, 1, 0, 0, 0, 1);
        chk("restart_next", 128'(ctr_block[3:0]), 128'h2);

        // Kill while a block is stalled
        step(0, 1, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("kill_block", ctr_block, 128'h0);
        for (int s = 0; s < int'(NS); s++) begin
            step(0, 1, WS'(s), 0, 0, 1);
            chk("kill_cnt1", 128'(ctr_block[3:0]), 128'h1);
        end

        // Out-of-range indices are ignored
        step(0, 1, 3, 1, 3, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("oor_s0", 128'(ctr_block[3:0]), 128'h2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                nonce_frame_id = {$urandom(), 16'($urandom())};
                nonce_addr_idx = 8'($urandom());
            end
            step(($urandom_range(0, 49) == 0), 1'($urandom()), WS'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), WS'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ccm_ctr_gen.md
CCM_CTR_GEN -- requirements
Module: ccm_ctr_gen

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 2: number of independent counter streams (1..16).
REQ-002 SHALL have parameter WIDTH_COUNT, default 20: per-stream block counter width.
REQ-003 SHALL have parameter WIDTH_SIDX, default $clog2(NUM_STREAMS) with minimum 1: stream index width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port kill, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port ccm_ctr_flag, input, 8: CCM counter flags byte.
REQ-007 SHALL have port nonce_sector_id, input, 4: nonce sector id.
REQ-008 SHALL have port nonce_frame_id, input, 48: nonce frame id.
REQ-009 SHALL have port nonce_start_slot_idx, input, 4: nonce start slot.
REQ-010 SHALL have port nonce_addr_idx, input, 8: nonce address.
REQ-011 SHALL have port in_valid, input, 1: counter-block request.
REQ-012 SHALL have port in_stream_idx, input, WIDTH_SIDX: stream of the request.
REQ-013 SHALL have port in_ready, output, 1: request accepted when in_valid & in_ready.
REQ-014 SHALL have port ctr_restart, input, 1: restart pulse for one stream.
REQ-015 SHALL have port ctr_restart_idx, input, WIDTH_SIDX: stream to restart.
REQ-016 SHALL have port out_valid, output, 1: ctr_block valid toward the AES core.
REQ-017 SHALL have port out_ready, input, 1: AES core takes the block.
REQ-018 SHALL have port ctr_block, output, 128: formatted counter block.
REQ-019 SHALL have port out_stream_idx, output, WIDTH_SIDX: stream of ctr_block.
REQ-020 SHALL have port ctr_overflow, output, NUM_STREAMS: sticky per-stream counter-exhausted flags.

Function
REQ-021 SHALL build ctr_block as {ccm_ctr_flag, nonce_sector_id, nonce_frame_id, nonce_start_slot_idx, nonce_addr_idx, stream index zero-extended to 56-WIDTH_COUNT bits, counter}, MSB first.
REQ-022 SHALL keep one WIDTH_COUNT counter per stream, starting at 1; each accepted request uses the current value, then the counter increments by 1.
REQ-023 SHALL register ctr_block/out_stream_idx/out_valid at acceptance: latency exactly 1 cycle.
REQ-024 SHALL drive in_ready = (~out_valid | out_ready) & ~ctr_overflow[in_stream_idx]; back-to-back acceptance every cycle while out_ready is high.
REQ-025 SHALL hold ctr_block, out_stream_idx and out_valid stable while out_valid & ~out_ready.
REQ-026 SHALL clear out_valid after the out_valid & out_ready cycle when no new request is accepted.
REQ-027 SHALL, on acceptance with the counter all-ones, issue that block, set ctr_overflow[stream] and not wrap to 0; further requests to that stream stall.
REQ-028 SHALL, on ctr_restart, set that stream's counter to 1 and clear its ctr_overflow the next cycle.
REQ-029 SHALL, on ctr_restart and acceptance for the same stream in one cycle, give restart priority: the block carries count 1 and the counter becomes 2.
REQ-030 SHALL leave counters of streams not addressed by a request or restart unchanged.
REQ-031 SHALL ignore in_stream_idx/ctr_restart_idx values >= NUM_STREAMS: in_ready low, and restart has no effect.

Reset
REQ-032 SHALL, while kill is high, set all counters to 1, ctr_overflow to 0, out_valid to 0, ctr_block to 0 and out_stream_idx to 0.
REQ-033 SHALL, when kill asserts mid-transfer, drop any pending block; no request is accepted in a kill cycle (in_ready low).

Structure
REQ-034 SHALL take field widths (flag 8, sector 4, frame 48, slot 4, addr 8, block 128) from the shared package ccm_pkg.
REQ-035 SHALL implement each per-stream counter and overflow flag in sub-module ccm_ctr_slice, instantiated NUM_STREAMS times by generate.
REQ-036 SHALL fail elaboration if WIDTH_SIDX + WIDTH_COUNT > 56 or NUM_STREAMS > 2**WIDTH_SIDX.

Verification
REQ-037 SHALL cover: after kill, flag=0x59, frame=0x1, requests stream0, stream0, stream1 with out_ready=1 -> ctr_block LSBs 1, 2, 1 on consecutive cycles, stream field 0, 0, 1.
REQ-038 SHALL cover: out_ready=0 for 3 cycles with in_valid high -> one block held stable, in_ready low, no counter advance, resume on release.
REQ-039 SHALL cover: WIDTH_COUNT=4, 15 requests on stream0 -> 15th block count 0xF, ctr_overflow[0]=1, stream0 stalls, stream1 still served.
REQ-040 SHALL cover: ctr_restart stream0 together with a stream0 request -> block count 1, next count 2, ctr_overflow[0] cleared.
REQ-041 SHALL cover: kill asserted while out_valid & ~out_ready -> out_valid 0 next cycle, next request on every stream yields count 1.
REQ-042 SHALL cover: NUM_STREAMS=3, request with in_stream_idx=3 -> in_ready low, no block issued.
